conv_linebuf_sched: RTL

Sequences one 3x3 convolution pass over a single-channel 8-bit image held packed in 32-bit BRAM words (4 pixels per word).
- Issues BRAM reads and unpacks the bytes into a pixel stream.
- Drives the write, read and reset controls of the two-row line-buffer FIFO.
- Flags the cycles on which a full, stride-aligned 3x3 window is present for the MAC array.

Sits between the image BRAM and the line-buffer FIFO / window registers in the convolution layer.

---
 rtl/conv_pkg.sv | 12 +
 rtl/conv_pos_counter.sv | 40 ++++
 rtl/conv_linebuf_sched.sv | 128 ++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the 3x3 convolution line-buffer scheduler.
package conv_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, FILL, RUN, DONE} conv_state_e;

  localparam int KSIZE   = 3;
  localparam int STRIDE1 = 1;
  localparam int STRIDE2 = 2;

  function automatic logic [2:0] stride_norm(input logic [2:0] s);
    return (s == 3'(STRIDE2)) ? 3'(STRIDE2) : 3'(STRIDE1);
  endfunction
endpackage

// File: rtl/conv_pos_counter.sv
// Row/column position of the pixel being written, with stride-phase bits.
module conv_pos_counter #(
  parameter int ADDR_BIT = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                adv,
  input  logic [ADDR_BIT-1:0] row_len,
  input  logic                stride2,
  output logic [ADDR_BIT-1:0] row,
  output logic [ADDR_BIT-1:0] col,
  output logic                row_ph,
  output logic                col_ph
);
  // Phase bits are 0 on stride-aligned positions; they stay 0 for stride 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row    <= '0;
      col    <= '0;
      row_ph <= 1'b0;
      col_ph <= 1'b0;
    end else if (clr) begin
      row    <= '0;
      col    <= '0;
      row_ph <= 1'b0;
      col_ph <= 1'b0;
    end else if (adv) begin
      if (col == row_len - ADDR_BIT'(1)) begin
        col    <= '0;
        col_ph <= 1'b0;
        row    <= row + ADDR_BIT'(1);
        row_ph <= stride2 & ~row_ph;
      end else begin
        col    <= col + ADDR_BIT'(1);
        col_ph <= stride2 & ~col_ph;
      end
    end
  end
endmodule

// File: rtl/conv_linebuf_sched.sv
// Issues packed-pixel BRAM reads, unpacks them into the line-buffer FIFO and
// flags stride-aligned complete 3x3 windows.
module conv_linebuf_sched
  import conv_pkg::*;
#(
  parameter int ADDR_BIT = 9,
  parameter int BRAM_AW  = 16,
  parameter int PIX_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          stride,
  input  logic [ADDR_BIT-1:0] row_len,
  input  logic [ADDR_BIT-1:0] n_rows,
  input  logic [BRAM_AW-1:0]  base_addr,
  output logic                bram_en,
  output logic [BRAM_AW-1:0]  bram_addr,
  input  logic [31:0]         bram_dout,
  input  logic                stall,
  output logic [PIX_W-1:0]    pix_data,
  output logic                ff_wen,
  output logic                ff_ren,
  output logic                ff_rst,
  output logic                win_valid,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);
  localparam int PW = 2 * ADDR_BIT;

  conv_state_e state, nxt;

  logic [ADDR_BIT-1:0] rl_r, nr_r;
  logic [BRAM_AW-1:0]  base_r;
  logic                strd2_r;
  logic [PW-1:0]       total_r, fill_end_r, p;
  logic                issue, bad_cfg, wr_last;

  logic                v2, ren2;
  logic [1:0]          sel2;
  logic [ADDR_BIT-1:0] row, col;
  logic                row_ph, col_ph;

  assign bad_cfg = (row_len < ADDR_BIT'(KSIZE)) || (n_rows < ADDR_BIT'(KSIZE));
  assign wr_last = v2 && (row == nr_r - ADDR_BIT'(1)) && (col == rl_r - ADDR_BIT'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // FILL->RUN keys off the issue index only, so stalls across it are harmless.
  always_comb begin
    nxt   = state;
    issue = 1'b0;
    case (state)
      IDLE:  if (start) nxt = bad_cfg ? DONE : CLEAR;
      CLEAR: nxt = FILL;
      FILL: begin
        issue = !stall;
        if (issue && p == fill_end_r - PW'(1)) nxt = RUN;
      end
      RUN: begin
        issue = !stall && (p < total_r);
        if (wr_last) nxt = DONE;
      end
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rl_r       <= '0;
      nr_r       <= '0;
      base_r     <= '0;
      strd2_r    <= 1'b0;
      total_r    <= '0;
      fill_end_r <= '0;
      cfg_err    <= 1'b0;
      p          <= '0;
      v2         <= 1'b0;
      ren2       <= 1'b0;
      sel2       <= '0;
    end else begin
      if (state == IDLE && start) begin
        rl_r       <= row_len;
        nr_r       <= n_rows;
        base_r     <= base_addr;
        strd2_r    <= (stride_norm(stride) == 3'(STRIDE2));
        total_r    <= PW'(row_len) * PW'(n_rows);
        fill_end_r <= PW'({row_len, 1'b0});
        cfg_err    <= bad_cfg;
        p          <= '0;
      end else if (issue) begin
        p <= p + PW'(1);
      end
      v2   <= issue;
      ren2 <= (state == RUN);
      sel2 <= p[1:0];
    end
  end

  conv_pos_counter #(.ADDR_BIT(ADDR_BIT)) u_pos (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == CLEAR),
    .adv     (v2),
    .row_len (rl_r),
    .stride2 (strd2_r),
    .row     (row),
    .col     (col),
    .row_ph  (row_ph),
    .col_ph  (col_ph)
  );

  assign bram_en   = issue;
  assign bram_addr = issue ? base_r + BRAM_AW'(p >> 2) : '0;
  assign pix_data  = v2 ? bram_dout[8*sel2 +: PIX_W] : '0;
  assign ff_wen    = v2;
  assign ff_ren    = v2 & ren2;
  assign ff_rst    = (state == CLEAR);
  assign win_valid = v2 && (row >= ADDR_BIT'(KSIZE-1)) && (col >= ADDR_BIT'(KSIZE-1))
                     && !row_ph && !col_ph;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
endmodule
